// File: rtl/stream_pkg.sv
// Shared defaults and FSM encoding for the frame source controller.
// Pixel width and frame geometry defaults target RGB565 720p.
package stream_pkg;

  localparam int DW_DEF    = 16;
  localparam int H_ACT_DEF = 1280;
  localparam int V_ACT_DEF = 720;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry pixel hold register; emits its pixel when the next one is loaded,
// or on its own in the cycle after it was loaded if it carries eop.
module stream_hold_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_sop,
  input  logic          load_eop,
  input  logic          force_eop,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          emit;

  assign emit = full_q & (eop_q | load);

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
      sop_d  = load_sop;
      eop_d  = load_eop;
    end else if (emit) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
    end
  end

  // force_eop closes the held frame when a new sop displaces it.
  assign dout     = data_q;
  assign dout_vld = emit;
  assign dout_sop = emit & sop_q;
  assign dout_eop = emit & (eop_q | force_eop);

endmodule

// File: rtl/frame_src_ctrl.sv
// Selects camera or test-pattern stream frame by frame, enforces frame length
// and reports malformed frames. Streams are valid-only: a pixel is transferred
// in every cycle its vld is high; there is no backpressure.
module frame_src_ctrl
  import stream_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic [DW-1:0] s0_din,
  input  logic [DW-1:0] s1_din,
  input  logic          s0_vld,
  input  logic          s1_vld,
  input  logic          s0_sop,
  input  logic          s1_sop,
  input  logic          s0_eop,
  input  logic          s1_eop,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          active_src,
  output logic          busy,
  output logic          frame_err,
  output logic [7:0]    err_cnt,
  output state_e        state_dbg
);

  localparam int             CW         = cnt_width(H_ACT * V_ACT);
  localparam logic [CW-1:0]  FRAME_LAST = CW'(H_ACT * V_ACT);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_src_q, active_src_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          src_sel;
  logic          in_vld, in_sop, in_eop;
  logic [DW-1:0] in_data;
  logic          acc, start, mid_sop, hold_eop, err;
  logic [CW-1:0] cnt_next;

  // Outside a frame the live sel picks the source; inside, the latched one does.
  assign src_sel = (state_q == ST_PASS) ? active_src_q : sel;
  assign in_vld  = src_sel ? s1_vld : s0_vld;
  assign in_sop  = src_sel ? s1_sop : s0_sop;
  assign in_eop  = src_sel ? s1_eop : s0_eop;
  assign in_data = src_sel ? s1_din : s0_din;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_src_d = active_src_q;
    acc          = 1'b0;
    start        = 1'b0;
    mid_sop      = 1'b0;
    hold_eop     = 1'b0;
    err          = 1'b0;

    if (state_q == ST_PASS) begin
      acc     = in_vld;
      start   = in_vld & in_sop;
      mid_sop = start;
    end else begin
      acc   = in_vld & in_sop;
      start = acc;
    end

    cnt_next = start ? CNT_ONE : cnt_q + CNT_ONE;

    if (acc) begin
      if (start) active_src_d = sel;
      if (in_eop) begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        hold_eop = 1'b1;
        err      = (cnt_next != FRAME_LAST);
      end else if (cnt_next == FRAME_LAST) begin
        // Frame is full but the source has not ended it: cut it here.
        state_d  = ST_DROP;
        cnt_d    = '0;
        hold_eop = 1'b1;
        err      = 1'b1;
      end else begin
        state_d = ST_PASS;
        cnt_d   = cnt_next;
      end
    end

    if (mid_sop) err = 1'b1;

    frame_err_d = err;
    err_cnt_d   = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      active_src_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_src_q <= active_src_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  stream_hold_reg #(.DW(DW)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc),
    .load_data (in_data),
    .load_sop  (start),
    .load_eop  (hold_eop),
    .force_eop (mid_sop),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop)
  );

  assign active_src = active_src_q;
  assign busy       = (state_q == ST_PASS);
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_frame_src_ctrl.sv
// Self-checking bench for frame_src_ctrl with a 4x2 frame: directed scenarios
// plus randomized two-source traffic against a frame-level reference model.
module tb_frame_src_ctrl;
  import stream_pkg::*;

  localparam int DW   = 16;
  localparam int MAXP = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sel;
  logic [DW-1:0] s0_din, s1_din;
  logic          s0_vld, s1_vld, s0_sop, s1_sop, s0_eop, s1_eop;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_sop, dout_eop;
  logic          active_src, busy, frame_err;
  logic [7:0]    err_cnt;
  state_e        state_dbg;

  frame_src_ctrl #(.DW(DW), .H_ACT(4), .V_ACT(2)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .s0_din(s0_din), .s1_din(s1_din),
    .s0_vld(s0_vld), .s1_vld(s1_vld),
    .s0_sop(s0_sop), .s1_sop(s1_sop),
    .s0_eop(s0_eop), .s1_eop(s1_eop),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .active_src(active_src), .busy(busy), .frame_err(frame_err),
    .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: output beats and frame_err pulses, each tagged with its due cycle
  typedef struct {
    logic [DW-1:0] d;
    bit            sop;
    bit            eop;
    int            due;
  } beat_t;

  beat_t exp_q[$];
  int    err_q[$];

  bit    m_open;
  bit    m_src;
  bit    m_pend_v;
  beat_t m_pend;
  int    m_cnt;
  int    m_errs;

  task automatic model_reset();
    m_open   = 1'b0;
    m_src    = 1'b0;
    m_pend_v = 1'b0;
    m_cnt    = 0;
    m_errs   = 0;
    exp_q.delete();
    err_q.delete();
  endtask

  // One clock of frame-level behaviour: decide which pixel the controller takes,
  // close the pixel waiting for its successor, and book frame errors.
  task automatic model_step();
    bit            use_src, v, so, eo, take, start, err;
    logic [DW-1:0] d;
    beat_t         p;
    use_src = m_open ? m_src : sel;
    v  = use_src ? s1_vld : s0_vld;
    so = use_src ? s1_sop : s0_sop;
    eo = use_src ? s1_eop : s0_eop;
    d  = use_src ? s1_din : s0_din;
    err = 1'b0;
    if (m_open) begin
      take  = v;
      start = v && so;
    end else begin
      take  = v && so;
      start = take;
    end
    if (take) begin
      if (m_pend_v) begin
        m_pend.eop = m_pend.eop | start;
        m_pend.due = cyc;
        exp_q.push_back(m_pend);
        m_pend_v = 1'b0;
      end
      if (start) begin
        if (m_open) err = 1'b1;
        m_src = sel;
        m_cnt = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      p.d   = d;
      p.sop = start;
      p.eop = eo;
      p.due = cyc + 1;
      if (eo) begin
        if (m_cnt != MAXP) err = 1'b1;
        exp_q.push_back(p);
        m_open = 1'b0;
      end else if (m_cnt == MAXP) begin
        err   = 1'b1;
        p.eop = 1'b1;
        exp_q.push_back(p);
        m_open = 1'b0;
      end else begin
        m_pend   = p;
        m_pend_v = 1'b1;
        m_open   = 1'b1;
      end
    end
    if (err) begin
      err_q.push_back(cyc + 1);
      if (m_errs < 255) m_errs++;
    end
  endtask

  task automatic tick();
    bit    e_busy, e_src, ev, ef;
    int    e_errs;
    beat_t b;
    @(negedge clk);
    e_busy = m_open;
    e_src  = m_src;
    e_errs = m_errs;
    model_step();
    chk("busy", busy, e_busy);
    chk("active_src", active_src, e_src);
    chk("err_cnt", err_cnt, e_errs);
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("dout_vld", dout_vld, ev);
    if (ev) begin
      b = exp_q.pop_front();
      chk("dout", dout, b.d);
      chk("dout_sop", dout_sop, b.sop);
      chk("dout_eop", dout_eop, b.eop);
    end else begin
      chk("sop_eop_quiet", {dout_sop, dout_eop}, 0);
    end
    ef = (err_q.size() > 0) && (err_q[0] == cyc);
    if (ef) void'(err_q.pop_front());
    chk("frame_err", frame_err, ef);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic drive(input bit s, input bit v, input bit so, input bit eo, input logic [DW-1:0] d);
    if (s) begin
      s1_vld = v; s1_sop = so; s1_eop = eo; s1_din = d;
    end else begin
      s0_vld = v; s0_sop = so; s0_eop = eo; s0_din = d;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (n) tick();
  endtask

  task automatic send_frame(input bit s, input int n, input int eop_at, input int sop2_at,
                            input logic [DW-1:0] base);
    sel = s;
    drive(~s, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 1; i <= n; i++) begin
      drive(s, 1'b1, (i == 1) || (i == sop2_at), (i == eop_at), base + DW'(i));
      tick();
    end
    drive(s, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_sop", dout_sop, 0);
    chk("rst_eop", dout_eop, 0);
    chk("rst_src", active_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // random traffic generators, one per source
  int g_idx[2];
  int g_len[2];
  bit g_eop[2];

  task automatic new_plan(input int s);
    int k;
    k = $urandom_range(0, 6);
    case (k)
      0, 1, 2: g_len[s] = 8;
      3:       g_len[s] = 5;
      4:       g_len[s] = 3;
      5:       g_len[s] = 10;
      default: g_len[s] = 6;
    endcase
    g_eop[s] = (k < 5);
    g_idx[s] = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // clean 8-pixel camera frame
    send_frame(1'b0, 8, 8, 0, 16'h0000);
    idle(2);
    chk("clean_errcnt", err_cnt, 0);

    // sel flips mid-frame; pattern source chatters, including a stray sop
    sel = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) sel = 1'b1;
      drive(1'b0, 1'b1, i == 1, i == 8, 16'h0040 + 16'(i));
      drive(1'b1, 1'b1, i == 5, 1'b0, 16'hF000 + 16'(i));
      tick();
    end
    send_frame(1'b1, 8, 8, 0, 16'h0050);
    idle(2);
    chk("switch_src", active_src, 1);
    chk("switch_errcnt", err_cnt, 0);

    // early eop on pixel 5
    do_reset();
    send_frame(1'b0, 5, 5, 0, 16'h0010);
    idle(2);
    chk("early_errcnt", err_cnt, 1);

    // 10 pixels, no eop
    do_reset();
    send_frame(1'b0, 10, 0, 0, 16'h0020);
    idle(2);
    chk("ovf_errcnt", err_cnt, 1);

    // restart sop on pixel 4, the new frame then runs its full 8 pixels
    do_reset();
    send_frame(1'b0, 11, 11, 4, 16'h0030);
    idle(2);
    chk("restart_errcnt", err_cnt, 1);

    // single-pixel frame with sop and eop together
    do_reset();
    send_frame(1'b1, 1, 1, 0, 16'h0077);
    idle(2);
    chk("single_errcnt", err_cnt, 1);

    // randomized two-source traffic
    do_reset();
    new_plan(0);
    new_plan(1);
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 3) != 0) begin
          g_idx[s]++;
          drive(s[0], 1'b1, g_idx[s] == 1, g_eop[s] && (g_idx[s] == g_len[s]), DW'($urandom));
          if (g_idx[s] == g_len[s]) new_plan(s);
        end else begin
          drive(s[0], 1'b0, 1'b0, 1'b0, DW'($urandom));
        end
      end
      tick();
    end
    idle(3);

    // error counter saturation
    do_reset();
    for (int k = 0; k < 256; k++) send_frame(1'b0, 2, 2, 0, 16'(k * 4));
    idle(2);
    chk("sat_errcnt", err_cnt, 255);

    // reset in the middle of a frame, then the tail of that frame arrives
    do_reset();
    send_frame(1'b0, 3, 0, 0, 16'h0090);
    do_reset();
    sel = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, i == 8, 16'h0090 + 16'(i));
      tick();
    end
    idle(3);
    chk("post_rst_errcnt", err_cnt, 0);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_src_ctrl.md
FRAME_SRC_CTRL -- requirements
Module: frame_src_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, pixel width (RGB565).
REQ-002 SHALL have parameter H_ACT, default 1280, pixels per line.
REQ-003 SHALL have parameter V_ACT, default 720, lines per frame.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sel  input  1  requested source (0 = camera, 1 = test pattern).
REQ-007 SHALL have ports s0_din/s1_din  input  DW  source pixel data.
REQ-008 SHALL have ports s0_vld/s1_vld, s0_sop/s1_sop, s0_eop/s1_eop  input  1 each  per-source valid, start-of-frame, end-of-frame.
REQ-009 SHALL have ports dout  output  DW; dout_vld, dout_sop, dout_eop  output  1 each; these feed img_process din/din_vld/din_sop/din_eop.
REQ-010 SHALL have port active_src  output  1  source of the frame in progress.
REQ-011 SHALL have port busy  output  1  high in PASS.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse per malformed frame.
REQ-013 SHALL have port err_cnt  output  8  saturating malformed-frame count.

Function
REQ-014 SHALL implement FSM states IDLE, PASS, DROP; reset state IDLE.
REQ-015 IDLE/DROP: a pixel with sop=1 (on the source selected by sel in that cycle) SHALL latch active_src=sel, set pixel count to 1 and enter PASS; every other pixel SHALL be discarded.
REQ-016 PASS: only pixels from active_src SHALL be accepted; the other source SHALL be ignored completely.
REQ-017 Each accepted pixel SHALL enter a one-entry hold register (data, sop, eop); output is the hold register, registered.
REQ-018 A held pixel without eop SHALL be emitted (dout_vld=1 for one cycle) in the cycle the next pixel is accepted; a held pixel with eop SHALL be emitted in the cycle after it was accepted, unconditionally.
REQ-019 Latency SHALL be exactly 1 clk for back-to-back valid input; the held pixel SHALL stay held while input stalls.
REQ-020 dout_sop SHALL be 1 only on the first pixel of each output frame; dout_eop only on the last.
REQ-021 Pixel count SHALL count accepted pixels, width ceil(log2(H_ACT*V_ACT+1)), reset to 0 on exit from PASS.
REQ-022 Normal end: eop at count == H_ACT*V_ACT SHALL forward eop, return to IDLE, no error.
REQ-023 Early eop (count < H_ACT*V_ACT, including sop and eop on the same pixel) SHALL forward eop, return to IDLE, pulse frame_err.
REQ-024 Overflow: count reaching H_ACT*V_ACT without eop SHALL force eop on that pixel, pulse frame_err, enter DROP.
REQ-025 Mid-frame sop on active_src SHALL force eop on the currently held pixel, pulse frame_err, and start a new frame per REQ-015 in the same cycle (sel re-sampled).
REQ-026 sel changes during PASS SHALL take effect only at the next frame start.
REQ-027 err_cnt SHALL increment on each frame_err pulse and saturate at 255.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, hold register empty, count 0, dout=0, dout_vld/sop/eop=0, active_src=0, busy=0, frame_err=0, err_cnt=0.
REQ-029 Reset mid-frame SHALL drop the partial frame without emitting eop; the first frame after release starts at the next sop.

Structure
REQ-030 Package stream_pkg SHALL hold DW, H_ACT, V_ACT defaults and the state encoding.
REQ-031 The hold register with forced-eop logic SHALL be sub-module stream_hold_reg; FSM, counter and error logic SHALL stay in frame_src_ctrl.

Verification (H_ACT=4, V_ACT=2)
REQ-032 sel=0, camera frame of 8 pixels 0x0001..0x0008 back-to-back -> dout 0x0001..0x0008 one cycle later, sop on 0x0001, eop on 0x0008, frame_err=0.
REQ-033 sel toggled to 1 mid-frame -> current frame completes from source 0; next frame taken from source 1, active_src=1.
REQ-034 Camera frame with eop on pixel 5 -> 5 pixels out, eop on pixel 5, frame_err pulse, err_cnt=1.
REQ-035 Frame of 10 pixels without eop -> 8 pixels out, eop forced on pixel 8, pixels 9-10 dropped, err_cnt=1.
REQ-036 sop on pixel 4 of a frame -> pixel 3 emitted with eop, new frame starts with pixel 4 as dout_sop, frame_err pulse.
REQ-037 256 consecutive early-eop frames -> err_cnt=255; rst_n pulse mid-frame -> all outputs 0, no eop emitted.
